// File: rtl/idft_out_capture_if.sv
// idft_out_capture_if: host-side valid/ready read stream carrying {Y3,Y2,Y1,Y0} words.
interface idft_out_capture_if #(parameter int DATA_W = 16);
    logic [4*DATA_W-1:0] rd_data;
    logic                rd_valid;
    logic                rd_ready;
    modport master(output rd_data, rd_valid, input rd_ready);
    modport slave(input rd_data, rd_valid, output rd_ready);
endinterface

// File: rtl/idft_out_capture.sv
// idft_out_capture: captures one IDFT output frame after next_out and drains it as 64-bit words.
module idft_out_capture #(
    parameter int DATA_W       = 16,
    parameter int FRAME_CYCLES = 32,
    parameter int ADDR_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   next_out,
    input  logic [DATA_W-1:0]      Y0,
    input  logic [DATA_W-1:0]      Y1,
    input  logic [DATA_W-1:0]      Y2,
    input  logic [DATA_W-1:0]      Y3,
    idft_out_capture_if.master     rd,
    output logic                   frame_ready,
    output logic                   busy,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [15:0]            frame_count
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [4*DATA_W-1:0] mem [FRAME_CYCLES];
    logic hs, last_wr, last_rd, cap_done, drain_done, ovf_evt;
    always_comb begin
        hs         = rd.rd_valid && rd.rd_ready;
        last_wr    = wr_ptr == ADDR_W'(FRAME_CYCLES - 1);
        last_rd    = rd_ptr == ADDR_W'(FRAME_CYCLES - 1);
        cap_done   = state == CAPTURE && last_wr;
        drain_done = state == DRAIN && hs && last_rd;
        // a pulse landing on the final handshake starts the next frame instead of overflowing
        ovf_evt    = next_out && state != IDLE && !drain_done;
        state_n    = (state == IDLE && next_out) ? CAPTURE :
                     cap_done                    ? DRAIN   :
                     drain_done                  ? (next_out ? CAPTURE : IDLE) : state;
    end
    assign rd.rd_valid = state == DRAIN;
    assign rd.rd_data  = mem[rd_ptr];
    assign frame_ready = rd.rd_valid;
    assign busy        = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            wr_ptr      <= (state == CAPTURE) ? wr_ptr + 1'b1 : '0;
            rd_ptr      <= (state == DRAIN) ? rd_ptr + ADDR_W'(hs) : '0;
            overflow    <= ovf_evt | (overflow & ~clear_overflow);
            frame_count <= frame_count + 16'(cap_done);
        end
    end
    always_ff @(posedge clk)
        if (state == CAPTURE) mem[wr_ptr] <= {Y3, Y2, Y1, Y0};
endmodule
